serie_a_paralelo_6bit: RTL and testbench
========================================

// Module: serie_a_paralelo_6bit
// PURPOSE
//  Upstream framer for the 6-bit 22-number comparator stage.
//  - Assembles MSB-first serial bits into ANCHO-bit words.
//  - Queues them in a small FIFO and presents them on a valid/ready interface.
//  - Salida drives the comparator's Entrada; Valido qualifies it.
// PARAMETERS
//  ANCHO        6   bits per word (comparator needs 6)
//  PROFUNDIDAD  2   FIFO depth in words; power of 2, >=2
// PORTS
//  Reloj         in   1      single clock, all logic on rising edge
//  Reset         in   1      synchronous, active-high
//  EntradaSerie  in   1      serial data bit
//  Habilitar     in   1      bit strobe; EntradaSerie sampled only when 1
//  Inicio        in   1      with Habilitar: this bit is the MSB of a new word
//  Salida        out  ANCHO  head-of-FIFO word
//  Valido        out  1      Salida holds a word
//  Listo         in   1      consumer accepts; pop when Valido&&Listo
//  Desborde      out  1      sticky: a completed word was dropped, FIFO full
//  ErrorParidad  out  1      1-cycle pulse on parity failure (see CONFIGURATION)
// BEHAVIOUR
//  Reset
//  - Salida=0, Valido=0, Desborde=0, ErrorParidad=0.
//  - FIFO empty; FSM in ESPERA; bit counter 0.
//  - Reset asserted mid-word or with FIFO non-empty discards everything.
//  FSM states
//  - ESPERA: ignore strobes without Inicio. Habilitar&&Inicio: shift bit in, cnt=1, go to CAPTURA.
//  - CAPTURA: each Habilitar shifts left, new bit to LSB, cnt++.
//    On the ANCHO-th bit: push to FIFO, go to ESPERA (or PARIDAD if enabled).
//    Habilitar&&Inicio here aborts the partial word; that bit becomes the new MSB, cnt=1.
//    Aborted words are never pushed.
//  - PARIDAD: macro builds only; described under CONFIGURATION.
//  Timing
//  - Habilitar=0 cycles are idle; the FSM holds state.
//  - Latency: the word is on Salida with Valido=1 the cycle after the last-bit strobe, if the FIFO was empty.
//  - Back-to-back words need no gap: the next word's Inicio may come on the strobe right after the last bit.
//  FIFO
//  - Pop when Valido&&Listo; Salida/Valido stable while Valido&&!Listo.
//  - Push and pop in the same cycle: both take effect, even when full (no drop).
//  - Push into a full FIFO without a pop: word dropped, Desborde=1 until Reset.
//  - Pop when empty: no effect.
//  - Pointers are log2(PROFUNDIDAD) bits and wrap naturally; an occupancy count of log2+1 bits decides full/empty.
// CONFIGURATION
//  Macro SERIE_PARIDAD_EN
//  - Defined:
//    - After the ANCHO data bits the FSM enters PARIDAD.
//    - The next Habilitar samples an even-parity bit.
//    - Parity OK: push the word.
//    - Bad parity: drop the word and pulse ErrorParidad for 1 cycle.
//    - Inicio in PARIDAD aborts, same as in CAPTURA.
//    - Latency is 1 cycle after the parity strobe.
//  - Undefined: no PARIDAD state; ErrorParidad tied 0.
// STRUCTURE
//  - Package serie_pkg: FSM state enum (ESPERA, CAPTURA, PARIDAD), default ANCHO=6, clog2 helper.
//  - Sub-module fifo_palabras: sync FIFO with push/pop, full/empty, data out.
//  - Top: FSM, shift register, bit counter, Desborde flag.
// TESTING
//  1 Serial 1,0,1,1,0,1 (Inicio on first), Listo=1 -> Salida=6'h2D, Valido=1 for 1 cycle.
//  2 Listo=0; send 6'h3F, 6'h01, then 6'h15 -> Valido held with Salida=6'h3F; Desborde=1.
//    Then Listo=1 -> pops 6'h3F, then 6'h01, then Valido=0.
//  3 Send 3 bits 1,1,1, then Inicio on 0,0,0,0,1,0 -> only 6'h02 emerges.
//  4 Full FIFO, Listo=1, word completes that same cycle -> no drop; Desborde stays 0.
//  5 Reset after 4 of 6 bits with 1 word queued -> Valido=0 next cycle.
//    Then a fresh 6'h2A arrives correctly.
//  6 With SERIE_PARIDAD_EN:
//    - 6'h2D + parity 0 -> emitted.
//    - 6'h2D + parity 1 -> dropped, ErrorParidad pulses 1 cycle.

Source files
------------

// File: rtl/serie_pkg.sv
// Shared types and helpers for the serial-to-parallel framer feeding the 6-bit comparator.
// Optional parity stage is selected with the SERIE_PARIDAD_EN macro.
package serie_pkg;

  localparam int ANCHO_DEF       = 6;
  localparam int PROFUNDIDAD_DEF = 2;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    CAPTURA = 2'd1,
    PARIDAD = 2'd2
  } estado_t;

  // Ceiling log2, never below 1 so a depth-2 FIFO still gets a 1-bit pointer.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serie_a_paralelo_6bit_fifo.sv
// fifo_palabras: synchronous word FIFO with simultaneous push/pop and a drop indication.
// Occupancy count (one bit wider than the pointers) decides full/empty.
module fifo_palabras
  import serie_pkg::*;
#(
  parameter int ANCHO       = ANCHO_DEF,
  parameter int PROFUNDIDAD = PROFUNDIDAD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [ANCHO-1:0] dato,
  input  logic             pop,
  output logic [ANCHO-1:0] salida,
  output logic             valido,
  output logic             descarte
);

  localparam int PW = clog2(PROFUNDIDAD);
  localparam int CW = PW + 1;

  logic [ANCHO-1:0] mem [PROFUNDIDAD];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cuenta;
  logic             vacio;
  logic             lleno;
  logic             do_push;
  logic             do_pop;

  assign vacio    = (cuenta == '0);
  assign lleno    = (cuenta == CW'(PROFUNDIDAD));
  assign do_pop   = pop & ~vacio;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
  assign do_push  = push & (~lleno | do_pop);
  assign descarte = push & lleno & ~do_pop;

  assign valido = ~vacio;
  assign salida = vacio ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cuenta <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cuenta <= cuenta + CW'(1);
        2'b01:   cuenta <= cuenta - CW'(1);
        default: cuenta <= cuenta;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count alone marks entries valid,
  // and the output is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= dato;
  end

endmodule

// File: rtl/serie_a_paralelo_6bit.sv
// Serial MSB-first word assembler with a small output FIFO for the 22-number comparator.
// Define SERIE_PARIDAD_EN to add a trailing even-parity bit check per word.
module serie_a_paralelo_6bit
  import serie_pkg::*;
#(
  parameter int ANCHO       = ANCHO_DEF,
  parameter int PROFUNDIDAD = PROFUNDIDAD_DEF
) (
  input  logic             Reloj,
  input  logic             Reset,
  input  logic             EntradaSerie,
  input  logic             Habilitar,
  input  logic             Inicio,
  input  logic             Listo,
  output logic [ANCHO-1:0] Salida,
  output logic             Valido,
  output logic             Desborde,
  output logic             ErrorParidad
);

  localparam int CW = clog2(ANCHO + 1);

  estado_t          estado, estado_n;
  logic [ANCHO-1:0] reg_d, reg_d_n;
  logic [ANCHO-1:0] dato_nuevo;
  logic [ANCHO-1:0] palabra;
  logic [CW-1:0]    cnt, cnt_n;
  logic             push;
  logic             descarte;
`ifdef SERIE_PARIDAD_EN
  logic             err_n;
  logic             err_q;
`endif

  assign dato_nuevo = {reg_d[ANCHO-2:0], EntradaSerie};

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    estado_n = estado;
    reg_d_n  = reg_d;
    cnt_n    = cnt;
    push     = 1'b0;
    palabra  = dato_nuevo;
`ifdef SERIE_PARIDAD_EN
    err_n    = 1'b0;
`endif
    if (Habilitar) begin
      if (Inicio) begin
        // Start of word in any state; a partial word is simply abandoned.
        reg_d_n  = {{(ANCHO-1){1'b0}}, EntradaSerie};
        cnt_n    = CW'(1);
        estado_n = CAPTURA;
      end else begin
        case (estado)
          CAPTURA: begin
            reg_d_n = dato_nuevo;
            if (cnt == CW'(ANCHO - 1)) begin
              cnt_n = '0;
`ifdef SERIE_PARIDAD_EN
              estado_n = PARIDAD;
`else
              push     = 1'b1;
              estado_n = ESPERA;
`endif
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
`ifdef SERIE_PARIDAD_EN
          PARIDAD: begin
            palabra  = reg_d;
            estado_n = ESPERA;
            if (^{reg_d, EntradaSerie} == 1'b0) push  = 1'b1;
            else                                err_n = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Reloj) begin
    if (Reset) begin
      estado   <= ESPERA;
      reg_d    <= '0;
      cnt      <= '0;
      Desborde <= 1'b0;
    end else begin
      estado   <= estado_n;
      reg_d    <= reg_d_n;
      cnt      <= cnt_n;
      Desborde <= Desborde | descarte;
    end
  end

`ifdef SERIE_PARIDAD_EN
  always_ff @(posedge Reloj) begin
    if (Reset) err_q <= 1'b0;
    else       err_q <= err_n;
  end
  assign ErrorParidad = err_q;
`else
  assign ErrorParidad = 1'b0;
`endif

  fifo_palabras #(
    .ANCHO       (ANCHO),
    .PROFUNDIDAD (PROFUNDIDAD)
  ) u_fifo (
    .clk      (Reloj),
    .reset    (Reset),
    .push     (push),
    .dato     (palabra),
    .pop      (Listo),
    .salida   (Salida),
    .valido   (Valido),
    .descarte (descarte)
  );

endmodule

// File: tb/tb_serie_a_paralelo_6bit.sv
// Directed bench for serie_a_paralelo_6bit; parity scenarios build when SERIE_PARIDAD_EN is defined.
// Observed vector is {Valido, Salida, Desborde, ErrorParidad}.
module tb_serie_a_paralelo_6bit;

  logic       Reloj = 1'b0;
  logic       Reset;
  logic       EntradaSerie;
  logic       Habilitar;
  logic       Inicio;
  logic       Listo;
  logic [5:0] Salida;
  logic       Valido;
  logic       Desborde;
  logic       ErrorParidad;
  logic [8:0] obs;

  int total  = 0;
  int passed = 0;

  assign obs = {Valido, Salida, Desborde, ErrorParidad};

  serie_a_paralelo_6bit dut (
    .Reloj        (Reloj),
    .Reset        (Reset),
    .EntradaSerie (EntradaSerie),
    .Habilitar    (Habilitar),
    .Inicio       (Inicio),
    .Listo        (Listo),
    .Salida       (Salida),
    .Valido       (Valido),
    .Desborde     (Desborde),
    .ErrorParidad (ErrorParidad)
  );

  always #5 Reloj = ~Reloj;

  // Top n bits of w, Inicio on the first; strobe left asserted for the caller.
  task automatic send_bits(input logic [5:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Reloj);
      Habilitar    = 1'b1;
      EntradaSerie = w[5-i];
      Inicio       = (i == 0);
    end
  endtask

  // Full word, back-to-back strobes; returns on the cycle after the final strobe.
  task automatic send_word(input logic [5:0] w, input logic listo_last, input logic par_flip);
    for (int i = 0; i < 6; i++) begin
      @(negedge Reloj);
      Habilitar    = 1'b1;
      EntradaSerie = w[5-i];
      Inicio       = (i == 0);
`ifndef SERIE_PARIDAD_EN
      if (i == 5 && listo_last) Listo = 1'b1;
`endif
    end
`ifdef SERIE_PARIDAD_EN
    @(negedge Reloj);
    EntradaSerie = (^w) ^ par_flip;
    Inicio       = 1'b0;
    if (listo_last) Listo = 1'b1;
`else
    if (par_flip) Inicio = 1'b0;
`endif
    @(negedge Reloj);
    Habilitar = 1'b0;
    Inicio    = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge Reloj);
    Habilitar = 1'b0;
    Inicio    = 1'b0;
    Reset     = 1'b1;
    @(negedge Reloj);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Habilitar = 1'b0; Inicio = 1'b0; EntradaSerie = 1'b0; Listo = 1'b0;
    repeat (2) @(negedge Reloj);
    total++;
    if (obs !== 9'b0) $display("FAIL reset_state: got %b expected %b", obs, 9'b0);
    else passed++;
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    Listo = 1'b1;
    send_word(6'h2D, 1'b0, 1'b0);
    total++;
    if (obs !== {1'b1, 6'h2D, 2'b00}) $display("FAIL basic_out: got %b expected %b", obs, {1'b1, 6'h2D, 2'b00});
    else passed++;
    @(negedge Reloj);
    total++;
    if (obs !== 9'b0) $display("FAIL basic_one_cycle: got %b expected %b", obs, 9'b0);
    else passed++;
  endtask

  task automatic test_overflow();
    Listo = 1'b0;
    send_word(6'h3F, 1'b0, 1'b0);
    total++;
    if (obs !== {1'b1, 6'h3F, 2'b00}) $display("FAIL ovf_first: got %b expected %b", obs, {1'b1, 6'h3F, 2'b00});
    else passed++;
    send_word(6'h01, 1'b0, 1'b0);
    total++;
    if (obs !== {1'b1, 6'h3F, 2'b00}) $display("FAIL ovf_hold: got %b expected %b", obs, {1'b1, 6'h3F, 2'b00});
    else passed++;
    send_word(6'h15, 1'b0, 1'b0);
    total++;
    if (obs !== {1'b1, 6'h3F, 2'b10}) $display("FAIL ovf_drop: got %b expected %b", obs, {1'b1, 6'h3F, 2'b10});
    else passed++;
    Listo = 1'b1;
    @(negedge Reloj);
    total++;
    if (obs !== {1'b1, 6'h01, 2'b10}) $display("FAIL ovf_pop1: got %b expected %b", obs, {1'b1, 6'h01, 2'b10});
    else passed++;
    @(negedge Reloj);
    total++;
    if (obs !== {1'b0, 6'h00, 2'b10}) $display("FAIL ovf_pop2: got %b expected %b", obs, {1'b0, 6'h00, 2'b10});
    else passed++;
    Listo = 1'b0;
    apply_reset();
    total++;
    if (obs !== 9'b0) $display("FAIL ovf_reset_clears: got %b expected %b", obs, 9'b0);
    else passed++;
  endtask

  task automatic test_abort();
    Listo = 1'b1;
    send_bits(6'b111000, 3);
`ifdef SERIE_PARIDAD_EN
    send_word(6'h02, 1'b0, 1'b0);
`else
    send_word(6'h02, 1'b0, 1'b0);
`endif
    total++;
    if (obs !== {1'b1, 6'h02, 2'b00}) $display("FAIL abort_word: got %b expected %b", obs, {1'b1, 6'h02, 2'b00});
    else passed++;
    @(negedge Reloj);
    total++;
    if (obs !== 9'b0) $display("FAIL abort_only_one: got %b expected %b", obs, 9'b0);
    else passed++;
  endtask

  task automatic test_simul_push_pop();
    Listo = 1'b0;
    send_word(6'h3F, 1'b0, 1'b0);
    send_word(6'h01, 1'b0, 1'b0);
    total++;
    if (obs !== {1'b1, 6'h3F, 2'b00}) $display("FAIL sim_full: got %b expected %b", obs, {1'b1, 6'h3F, 2'b00});
    else passed++;
    send_word(6'h2A, 1'b1, 1'b0);
    total++;
    if (obs !== {1'b1, 6'h01, 2'b00}) $display("FAIL sim_no_drop: got %b expected %b", obs, {1'b1, 6'h01, 2'b00});
    else passed++;
    @(negedge Reloj);
    total++;
    if (obs !== {1'b1, 6'h2A, 2'b00}) $display("FAIL sim_third: got %b expected %b", obs, {1'b1, 6'h2A, 2'b00});
    else passed++;
    @(negedge Reloj);
    total++;
    if (obs !== 9'b0) $display("FAIL sim_drained: got %b expected %b", obs, 9'b0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    Listo = 1'b0;
    send_word(6'h15, 1'b0, 1'b0);
    send_bits(6'h3F, 4);
    apply_reset();
    total++;
    if (obs !== 9'b0) $display("FAIL mid_reset_flush: got %b expected %b", obs, 9'b0);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge Reloj);
      Habilitar = 1'b1; EntradaSerie = 1'b1; Inicio = 1'b0;
    end
    @(negedge Reloj);
    Habilitar = 1'b0;
    total++;
    if (obs !== 9'b0) $display("FAIL mid_reset_no_resume: got %b expected %b", obs, 9'b0);
    else passed++;
    send_word(6'h2A, 1'b0, 1'b0);
    total++;
    if (obs !== {1'b1, 6'h2A, 2'b00}) $display("FAIL mid_reset_fresh: got %b expected %b", obs, {1'b1, 6'h2A, 2'b00});
    else passed++;
    Listo = 1'b1;
    @(negedge Reloj);
    total++;
    if (obs !== 9'b0) $display("FAIL mid_reset_drain: got %b expected %b", obs, 9'b0);
    else passed++;
  endtask

  // Idle gaps between strobes, plus a stray Inicio without Habilitar mid-word.
  task automatic test_idle_gaps();
    logic [5:0] w;
    w = 6'h33;
    Listo = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Reloj);
      Habilitar = 1'b1; EntradaSerie = w[5-i]; Inicio = (i == 0);
      @(negedge Reloj);
      Habilitar = 1'b0; EntradaSerie = 1'b0; Inicio = (i == 2);
    end
`ifdef SERIE_PARIDAD_EN
    @(negedge Reloj);
    Habilitar = 1'b1; EntradaSerie = ^w; Inicio = 1'b0;
    @(negedge Reloj);
    Habilitar = 1'b0;
`endif
    total++;
    if (obs !== {1'b1, 6'h33, 2'b00}) $display("FAIL idle_word: got %b expected %b", obs, {1'b1, 6'h33, 2'b00});
    else passed++;
    Listo = 1'b1;
    @(negedge Reloj);
    total++;
    if (obs !== 9'b0) $display("FAIL idle_drain: got %b expected %b", obs, 9'b0);
    else passed++;
  endtask

`ifdef SERIE_PARIDAD_EN
  task automatic test_parity();
    Listo = 1'b1;
    send_word(6'h2D, 1'b0, 1'b0);
    total++;
    if (obs !== {1'b1, 6'h2D, 2'b00}) $display("FAIL par_good: got %b expected %b", obs, {1'b1, 6'h2D, 2'b00});
    else passed++;
    @(negedge Reloj);
    send_word(6'h2D, 1'b0, 1'b1);
    total++;
    if (obs !== {1'b0, 6'h00, 2'b01}) $display("FAIL par_bad_pulse: got %b expected %b", obs, {1'b0, 6'h00, 2'b01});
    else passed++;
    @(negedge Reloj);
    total++;
    if (obs !== 9'b0) $display("FAIL par_pulse_one_cycle: got %b expected %b", obs, 9'b0);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_abort();
    test_simul_push_pop();
    test_reset_mid();
    test_idle_gaps();
`ifdef SERIE_PARIDAD_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
